// File: rtl/if_id_pipe_reg.sv
// IF->ID elastic pipeline register with a two-entry skid buffer, synchronous flush,
// NOP bubble on idle output and a saturating back-pressure cycle counter.
// Data vectors are packed as {pc, instruction, pc_plus4}, MSB first.
module if_id_pipe_reg #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  NOP_INST   = DATA_WIDTH'(32'h0000_0013),
    parameter int unsigned            CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [3*DATA_WIDTH-1:0]   in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [3*DATA_WIDTH-1:0]   out_data_o,
    input  logic                      flush_i,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

    localparam int unsigned ENTRY_W = 3 * DATA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e                 state_q, state_d;
    logic [ENTRY_W-1:0]   main_q, main_d;
    logic [ENTRY_W-1:0]   skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 in_fire, out_fire;

    // Occupancy next-state and entry movement; flush overrides every handshake.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_fire  = in_valid_i & in_ready_q;
        out_fire = (state_q != EMPTY) & out_ready_i;
        if (flush_i) begin
            state_d = EMPTY;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is registered from the next occupancy so IF never sees a combinational path.
        in_ready_d = (state_d != FULL);
    end

    // Saturating count of cycles where ID holds off a valid instruction.
    always_comb begin
        stall_d = stall_q;
        if ((state_q != EMPTY) && !out_ready_i && !flush_i && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset dominates flush and handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    // Outputs: head entry when valid, otherwise a NOP bubble with zero pc fields.
    always_comb begin
        out_valid_o    = (state_q != EMPTY);
        in_ready_o     = in_ready_q;
        stall_cycles_o = stall_q;
        if (state_q != EMPTY) begin
            out_data_o = main_q;
        end else begin
            out_data_o = {{DATA_WIDTH{1'b0}}, NOP_INST, {DATA_WIDTH{1'b0}}};
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_if_id_pipe_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned EW = 3 * DW;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [EW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [EW-1:0] out_data_o;
    logic          flush_i = 1'b0;
    logic [CW-1:0] stall_cycles_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [EW-1:0] mq[$];
    int unsigned   mcnt = 0;

    if_id_pipe_reg #(
        .DATA_WIDTH (DW),
        .NOP_INST   (32'h0000_0013),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .flush_i        (flush_i),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [DW-1:0] pc);
        logic [DW-1:0] ins;
        ins = $urandom;
        return {pc, ins, pc + 32'd4};
    endfunction

    // One clock: drive inputs, advance the model by the interface rules, compare after the edge.
    task automatic cycle(input logic v, input logic [EW-1:0] d, input logic ordy,
                         input logic fl, input logic rn);
        logic m_valid, m_ready, ifire, ofire;
        logic [EW-1:0] exp_data;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        rst_n       = rn;
        m_valid = (mq.size() > 0);
        m_ready = (mq.size() < 2);
        ifire   = v & m_ready;
        ofire   = m_valid & ordy;
        @(posedge clk);
        #1;
        if (!rn) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (m_valid && !ordy && !fl && mcnt < CMAX) mcnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(d);
            end
        end
        exp_data = (mq.size() > 0) ? mq[0] : {32'h0, 32'h0000_0013, 32'h0};
        check("out_valid", EW'(out_valid_o), EW'(mq.size() > 0));
        check("in_ready", EW'(in_ready_o), EW'(mq.size() < 2));
        check("out_data", out_data_o, exp_data);
        check("stall_cnt", EW'(stall_cycles_o), EW'(mcnt));
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset held two cycles
        cycle(1'b1, ent(32'h100), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ent(32'h104), 1'b1, 1'b1, 1'b0);
        check("rst_valid", EW'(out_valid_o), EW'(0));
        check("rst_ready", EW'(in_ready_o), EW'(1));
        check("rst_instr", EW'(out_data_o[63:32]), EW'(32'h13));
        check("rst_stall", EW'(stall_cycles_o), EW'(0));

        // Streaming
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, ent(32'(i * 4)), 1'b1, 1'b0, 1'b1);
            check("stream_pc", EW'(out_data_o[95:64]), EW'(i * 4));
            check("stream_pc4", EW'(out_data_o[31:0]), EW'(i * 4 + 4));
        end
        idle(2);

        // Back-pressure into skid
        cycle(1'b1, ent(32'h10), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, ent(32'h14), 1'b0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, ent(32'h18), 1'b0, 1'b0, 1'b1);
        check("bp_ready", EW'(in_ready_o), EW'(0));
        check("bp_head", EW'(out_data_o[95:64]), EW'(32'h10));
        check("bp_stall", EW'(stall_cycles_o), EW'(4));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("bp_rel1", EW'(out_data_o[95:64]), EW'(32'h14));
        idle(2);

        // Flush while full
        cycle(1'b1, ent(32'h20), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, ent(32'h24), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, ent(32'h28), 1'b0, 1'b1, 1'b1);
        check("fl_valid", EW'(out_valid_o), EW'(0));
        cycle(1'b1, ent(32'h40), 1'b1, 1'b0, 1'b1);
        check("fl_next", EW'(out_data_o[95:64]), EW'(32'h40));
        idle(2);

        // Simultaneous in/out fire in ONE
        cycle(1'b1, ent(32'h50), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, ent(32'h54), 1'b1, 1'b0, 1'b1);
        check("sim_head", EW'(out_data_o[95:64]), EW'(32'h54));
        idle(2);

        // Random traffic
        for (int unsigned i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), ent($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) != 0));
        end

        // Counter saturation
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, ent(32'h60), 1'b1, 1'b0, 1'b1);
        for (int unsigned i = 0; i < (1 << CW) + 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("sat_val", EW'(stall_cycles_o), EW'(4'hF));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("sat_hold", EW'(stall_cycles_o), EW'(4'hF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
